// File: rtl/alu_pipe_pkg.sv
// Shared constants for alu_pipe: RV32 opcode field values, func3 encodings and
// the execute-stage state encoding.
package alu_pipe_pkg;

    // inst[6:2] opcode values
    localparam logic [4:0] OP_R_TYPE = 5'b01100;
    localparam logic [4:0] OP_IMME   = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_pipe_muldiv.sv
// Iterative M-extension core: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up applied on the result.
module alu_pipe_muldiv
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN-1:0] hi_reg, lo_reg, dvs_reg, spec_res_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      f3_reg;
    logic            run_reg, spec_reg, neg_reg, neg_rem_reg;

    logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_val;

    always_comb begin
        is_div   = func3[2];
        a_signed = 1'b1;
        b_signed = 1'b1;
        case (func3)
            F3_MULHSU:                   b_signed = 1'b0;
            F3_MULHU, F3_DIVU, F3_REMU: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
            default: ;
        endcase
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && a_signed && (a == MOST_NEG) && (b == '1);
        special  = div_zero || div_ovf;
        // func3[1] separates REM* from DIV* within the divide group
        if (func3[1]) spec_val = div_zero ? a : '0;
        else          spec_val = div_zero ? '1 : a;
    end

    logic [XLEN:0]   mul_sum, div_shift, div_trial;
    logic [XLEN-1:0] hi_next, lo_next;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvs_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_trial = div_shift - {1'b0, dvs_reg};
        hi_next   = mul_sum[XLEN:1];
        lo_next   = {mul_sum[0], lo_reg[XLEN-1:1]};
        if (f3_reg[2]) begin
            if (!div_trial[XLEN]) begin
                hi_next = div_trial[XLEN-1:0];
                lo_next = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                hi_next = div_shift[XLEN-1:0];
                lo_next = {lo_reg[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [2*XLEN-1:0] prod;

    always_comb begin
        prod = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        if (spec_reg) begin
            result = spec_res_reg;
        end else begin
            case (f3_reg)
                F3_MUL:                        result = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:               result = neg_reg ? -lo_reg : lo_reg;
                default:                       result = neg_rem_reg ? -hi_reg : hi_reg;
            endcase
        end
    end

    assign done = run_reg && (cnt_reg == CW'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            dvs_reg      <= '0;
            spec_res_reg <= '0;
            cnt_reg      <= '0;
            f3_reg       <= '0;
            run_reg      <= 1'b0;
            spec_reg     <= 1'b0;
            neg_reg      <= 1'b0;
            neg_rem_reg  <= 1'b0;
        end else if (flush) begin
            run_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (start) begin
            f3_reg       <= func3;
            cnt_reg      <= '0;
            spec_reg     <= special;
            spec_res_reg <= spec_val;
            run_reg      <= !special;
            hi_reg       <= '0;
            // lo holds multiplier / dividend, dvs holds multiplicand / divisor
            lo_reg       <= is_div ? a_mag : b_mag;
            dvs_reg      <= is_div ? b_mag : a_mag;
            neg_reg      <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
        end else if (run_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (done) run_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with a registered result. Define ALU_PIPE_MULDIV_EN
// to add the iterative M-extension unit; otherwise every op is single cycle.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      opcode,
    input  logic [2:0]      func3,
    input  logic            func7_b5,
    input  logic            func7_b0,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            busy
);
    state_t          state_reg;
    logic            accept, is_m;
    logic [XLEN-1:0] base_res;

    assign in_ready = (state_reg == ST_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MULDIV_EN
    logic            md_special, md_done;
    logic [XLEN-1:0] md_result;

    assign is_m = (opcode == OP_R_TYPE) && func7_b0;
    assign busy = (state_reg == ST_MUL) || (state_reg == ST_DIV);

    alu_pipe_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (accept && is_m),
        .func3   (func3),
        .a       (operand1),
        .b       (operand2),
        .special (md_special),
        .done    (md_done),
        .result  (md_result)
    );
`else
    logic unused_func7_b0;
    assign unused_func7_b0 = func7_b0;
    assign is_m = 1'b0;
    assign busy = 1'b0;
`endif

    logic [XLEN-1:0] add_res, sub_res;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, br_taken;

    always_comb begin
        add_res  = operand1 + operand2;
        sub_res  = operand1 - operand2;
        shamt    = operand2[SHW-1:0];
        lt_s     = $signed(operand1) < $signed(operand2);
        lt_u     = operand1 < operand2;
        br_taken = 1'b0;
        case (func3)
            F3_BEQ:  br_taken = (operand1 == operand2);
            F3_BNE:  br_taken = (operand1 != operand2);
            F3_BLT:  br_taken = lt_s;
            F3_BGE:  br_taken = !lt_s;
            F3_BLTU: br_taken = lt_u;
            F3_BGEU: br_taken = !lt_u;
            default: br_taken = 1'b0;
        endcase

        base_res = '0;
        case (opcode)
            OP_R_TYPE, OP_IMME: begin
                case (func3)
                    // immediate ADDI has no subtract form even when inst[30] is set
                    F3_ADD:  base_res = (opcode == OP_R_TYPE && func7_b5) ? sub_res : add_res;
                    F3_SLL:  base_res = operand1 << shamt;
                    F3_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_s};
                    F3_SLTU: base_res = {{(XLEN-1){1'b0}}, lt_u};
                    F3_XOR:  base_res = operand1 ^ operand2;
                    F3_SR:   base_res = func7_b5 ? $unsigned($signed(operand1) >>> shamt)
                                                 : operand1 >> shamt;
                    F3_OR:   base_res = operand1 | operand2;
                    F3_AND:  base_res = operand1 & operand2;
                    default: base_res = '0;
                endcase
            end
            OP_LOAD, OP_STORE, OP_AUIPC: base_res = add_res;
            OP_JAL, OP_JALR:             base_res = operand1 + XLEN'(4);
            OP_LUI:                      base_res = operand2;
            OP_BRANCH:                   base_res = {{(XLEN-1){1'b0}}, br_taken};
            default:                     base_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && !is_m) begin
                        alu_out   <= base_res;
                        out_valid <= 1'b1;
                    end else begin
                        if (out_ready) out_valid <= 1'b0;
`ifdef ALU_PIPE_MULDIV_EN
                        // func3[2] separates the divide group from the multiply group
                        if (accept) state_reg <= md_special ? ST_FIN : (func3[2] ? ST_DIV : ST_MUL);
`endif
                    end
                end
`ifdef ALU_PIPE_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (md_done) state_reg <= ST_FIN;
                end
                ST_FIN: begin
                    alu_out   <= md_result;
                    out_valid <= 1'b1;
                    state_reg <= ST_IDLE;
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe; the M-extension sequences run only
// when ALU_PIPE_MULDIV_EN is defined.
module tb_alu_pipe;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        func7_b5, func7_b0;
    logic [31:0] operand1, operand2;
    logic        flush, out_valid, out_ready, busy;
    logic [31:0] alu_out;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_pipe #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .func3     (func3),
        .func7_b5  (func7_b5),
        .func7_b0  (func7_b0),
        .operand1  (operand1),
        .operand2  (operand2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] R = 5'b01100, I = 5'b00100, LD = 5'b00000, ST = 5'b01000;
    localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000;
    localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        b5;
        logic        b0;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } mvec_t;

    vec_t  vecs[$];
    mvec_t mvecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic b5,
                         input logic b0, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        opcode   = op;
        func3    = f3;
        func7_b5 = b5;
        func7_b0 = b0;
        operand1 = a;
        operand2 = b;
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [2:0] f3, input logic b5,
                                input logic b0, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.b5 = b5; v.b0 = b0; v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    function automatic mvec_t mkm(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp, input int lat);
        mvec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = 8'(lat);
        return v;
    endfunction

    // M-op: accept, then count cycles until out_valid (bounded)
    task automatic run_m(input int idx, input mvec_t v);
        int lat;
        drive(R, v.f3, 1'b0, 1'b1, v.a, v.b);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        chk("m_busy_start", {31'b0, busy}, {31'b0, (v.lat > 8'd2)});
        chk("m_in_ready_stall", {31'b0, in_ready}, 32'd0);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("m_latency", lat, {24'b0, v.lat});
        chk("m_result", alu_out, v.exp);
        $display("mvec %0d f3=%b a=%08h b=%08h -> %08h after %0d cycles", idx, v.f3, v.a, v.b, alu_out, lat);
        @(negedge clk);
        chk("m_consumed", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; opcode = '0; func3 = '0; func7_b5 = 1'b0; func7_b0 = 1'b0;
        operand1 = '0; operand2 = '0; flush = 1'b0; out_ready = 1'b1;

        vecs.push_back(mk(R,   3'b000, 1, 0, 32'd3,        32'd5,        32'hFFFFFFFE));
        vecs.push_back(mk(R,   3'b101, 1, 0, 32'h80000000, 32'd31,       32'hFFFFFFFF));
        vecs.push_back(mk(BR,  3'b110, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd1));
        vecs.push_back(mk(JAL, 3'b000, 0, 0, 32'h100,      32'h20,       32'h104));
        vecs.push_back(mk(R,   3'b000, 0, 0, 32'h7FFFFFFF, 32'd1,        32'h80000000));
        vecs.push_back(mk(I,   3'b000, 1, 0, 32'd10,       32'hFFFFFFFF, 32'd9));
        vecs.push_back(mk(R,   3'b001, 0, 0, 32'd1,        32'd35,       32'd8));
        vecs.push_back(mk(R,   3'b010, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd1));
        vecs.push_back(mk(R,   3'b011, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0));
        vecs.push_back(mk(I,   3'b100, 0, 0, 32'hF0,       32'hFF,       32'h0F));
        vecs.push_back(mk(R,   3'b101, 0, 0, 32'h80000000, 32'd31,       32'd1));
        vecs.push_back(mk(I,   3'b101, 1, 0, 32'hF0000000, 32'd4,        32'hFF000000));
        vecs.push_back(mk(I,   3'b101, 0, 0, 32'h80000000, 32'd4,        32'h08000000));
        vecs.push_back(mk(R,   3'b110, 0, 0, 32'hF0,       32'h0F,       32'hFF));
        vecs.push_back(mk(R,   3'b111, 0, 0, 32'hF0,       32'h3C,       32'h30));
        vecs.push_back(mk(LUI, 3'b000, 0, 0, 32'h1234,     32'hABCDE000, 32'hABCDE000));
        vecs.push_back(mk(AUIPC,3'b000,0, 0, 32'h1000,     32'h2000,     32'h3000));
        vecs.push_back(mk(LD,  3'b010, 0, 0, 32'h100,      32'hFFFFFFFC, 32'hFC));
        vecs.push_back(mk(ST,  3'b010, 0, 0, 32'h200,      32'd8,        32'h208));
        vecs.push_back(mk(JALR,3'b000, 0, 0, 32'h400,      32'h10,       32'h404));
        vecs.push_back(mk(BR,  3'b000, 0, 0, 32'd5,        32'd5,        32'd1));
        vecs.push_back(mk(BR,  3'b001, 0, 0, 32'd5,        32'd5,        32'd0));
        vecs.push_back(mk(BR,  3'b100, 0, 0, 32'hFFFFFFFF, 32'd0,        32'd1));
        vecs.push_back(mk(BR,  3'b101, 0, 0, 32'hFFFFFFFF, 32'd0,        32'd0));
        vecs.push_back(mk(BR,  3'b111, 0, 0, 32'hFFFFFFFF, 32'd0,        32'd1));
        vecs.push_back(mk(BR,  3'b010, 0, 0, 32'd1,        32'd2,        32'd0));
        vecs.push_back(mk(5'b11111, 3'b000, 0, 0, 32'd1,   32'd2,        32'd0));
`ifndef ALU_PIPE_MULDIV_EN
        // without the M unit, func7_b0 is ignored and func3 picks the base op
        vecs.push_back(mk(R,   3'b000, 0, 1, 32'd7,        32'd3,        32'd10));
        vecs.push_back(mk(R,   3'b100, 0, 1, 32'hF0,       32'hFF,       32'h0F));
`endif

        mvecs.push_back(mkm(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34));
        mvecs.push_back(mkm(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34));
        mvecs.push_back(mkm(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34));
        mvecs.push_back(mkm(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34));
        mvecs.push_back(mkm(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34));
        mvecs.push_back(mkm(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34));
        mvecs.push_back(mkm(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34));
        mvecs.push_back(mkm(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34));
        mvecs.push_back(mkm(3'b101, 32'd100,      32'd7,        32'd14,       34));
        mvecs.push_back(mkm(3'b111, 32'd100,      32'd7,        32'd2,        34));
        mvecs.push_back(mkm(3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 2));
        mvecs.push_back(mkm(3'b110, 32'd7,        32'd0,        32'd7,        2));
        mvecs.push_back(mkm(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2));
        mvecs.push_back(mkm(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2));

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_alu_out", alu_out, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // base ops back to back at one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            chk("base_in_ready", {31'b0, in_ready}, 32'd1);
            drive(vecs[i].op, vecs[i].f3, vecs[i].b5, vecs[i].b0, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk("base_out_valid", {31'b0, out_valid}, 32'd1);
            chk("base_result", alu_out, vecs[i].exp);
            $display("vec %0d op=%b f3=%b a=%08h b=%08h -> %08h", i, vecs[i].op, vecs[i].f3,
                     vecs[i].a, vecs[i].b, alu_out);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("base_drain", {31'b0, out_valid}, 32'd0);

`ifdef ALU_PIPE_MULDIV_EN
        for (int i = 0; i < mvecs.size(); i++) run_m(i, mvecs[i]);
`endif

        // backpressure: result held, new op waits, then consume+accept together
        out_ready = 1'b0;
        drive(R, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
        @(negedge clk);
        drive(R, 3'b110, 1'b0, 1'b0, 32'hF0, 32'h0F);
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_alu_out", alu_out, 32'd3);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            $display("hold cycle %0d alu_out=%08h in_ready=%0b", k, alu_out, in_ready);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("reload_out_valid", {31'b0, out_valid}, 32'd1);
        chk("reload_alu_out", alu_out, 32'hFF);
        $display("consume+accept -> %08h", alu_out);
        @(negedge clk);
        chk("reload_drain", {31'b0, out_valid}, 32'd0);

        // flush drops a held result and masks in_ready
        out_ready = 1'b0;
        drive(R, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_pre_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_drops_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_masks_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_ready_back", {31'b0, in_ready}, 32'd1);
        $display("flush of held result done");

`ifdef ALU_PIPE_MULDIV_EN
        // flush at DIVU iteration 10
        drive(R, 3'b101, 1'b0, 1'b1, 32'h0000FFFF, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("divu_busy_iter10", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("divflush_busy", {31'b0, busy}, 32'd0);
        chk("divflush_valid", {31'b0, out_valid}, 32'd0);
        #1;
        chk("divflush_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("divflush_no_result", seen, 32'd0);
        drive(R, 3'b100, 1'b0, 1'b0, 32'hF0, 32'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_flush_xor", alu_out, 32'h0F);
        $display("flushed DIVU, then XOR -> %08h", alu_out);
        @(negedge clk);

        // asynchronous reset in the middle of a divide
        drive(R, 3'b100, 1'b0, 1'b1, 32'd100, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", {31'b0, busy}, 32'd1);
`else
        out_ready = 1'b0;
        drive(R, 3'b000, 1'b0, 1'b0, 32'h55, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_reset_alu_out", alu_out, 32'h55);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, out_valid}, 32'd0);
        chk("async_reset_alu_out", alu_out, 32'd0);
        chk("async_reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        drive(R, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_reset_add_valid", {31'b0, out_valid}, 32'd1);
        chk("post_reset_add", alu_out, 32'd12);
        $display("after reset ADD 5+7 -> %0d", alu_out);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
